dpcomp_flag_stage: RTL and testbench
====================================

// Module: dpcomp_flag_stage
// PURPOSE
//  Downstream consumer of the comparator/lookahead datapath column. Captures the
//  column's Y result word and its COUT/COUTBAR carry rail pair, and derives Z/N/C
//  flags from them. Holds the results in a 2-entry skid buffer behind a
//  valid/ready handshake, feeding the condition-flag/branch logic.
//  Also flags carry-rail faults, i.e. COUT not the complement of COUTBAR.
// PARAMETERS
//  WIDTH  32  datapath width; number of comparator slices in the column
// PORTS
//  CLK        in   1      clock, all state updates on rising edge
//  RESETBAR   in   1      asynchronous reset, active-low
//  IN_VALID   in   1      column outputs valid this cycle
//  IN_READY   out  1      stage can accept a result
//  Y          in   WIDTH  comparator column result word
//  COUT       in   1      carry/compare out of the MSB slice
//  COUTBAR    in   1      complement rail of COUT
//  OUT_VALID  out  1      head entry valid
//  OUT_READY  in   1      consumer takes head entry
//  RESULT     out  WIDTH  head entry result word
//  ZFLAG      out  1      head entry: RESULT == 0
//  NFLAG      out  1      head entry: RESULT[WIDTH-1]
//  CFLAG      out  1      head entry: captured COUT
//  RAILERR    out  1      sticky carry-rail fault
//  CLRERR     in   1      synchronous clear of RAILERR
//  COUNT      out  2      entries held, 0..2
// BEHAVIOUR
//  Reset (RESETBAR=0, async): COUNT=0, OUT_VALID=0, RESULT=0, Z/N/CFLAG=0,
//    RAILERR=0, IN_READY=1. Reset mid-operation discards all held entries.
//  Storage: 2 entries, each {Y, Z, N, C}. Head pointer and tail pointer are 1 bit each
//    and wrap. Flags are computed at capture, not at read.
//  Push: IN_VALID & IN_READY at a rising edge; the entry is written at the tail.
//  Pop: OUT_VALID & OUT_READY at a rising edge; the head pointer advances.
//  IN_READY = (COUNT != 2). It is a function of registered state only and never
//    depends on OUT_READY.
//  OUT_VALID = (COUNT != 0). RESULT and the flags show the head entry. They are
//    stable while OUT_VALID=1 and OUT_READY=0.
//  Latency: a push at edge k makes the data visible on the outputs after edge k
//    when the stage was empty. Throughput is 1 entry per cycle with OUT_READY held high.
//  Simultaneous push+pop:
//    COUNT=1: COUNT stays 1 and the head moves to the new entry.
//    COUNT=2: no push, because IN_READY=0. COUNT becomes 1.
//    COUNT=0: push only; a pop is impossible because OUT_VALID=0.
//  When the stage is empty, RESULT and the flags hold the last popped values. The
//    consumer must gate on OUT_VALID.
//  Rail check: on each push, if COUT==COUTBAR or either rail is X/Z, RAILERR is set
//    at that edge. The entry is still stored, with CFLAG=COUT (X propagates).
//  RAILERR stays set until CLRERR=1 at an edge. If a set and CLRERR occur in the
//    same cycle, set wins.
//  Y containing X: ZFLAG and NFLAG follow normal Verilog evaluation (X allowed).
//    No other error is raised.
//  COUNT is never above 2 and never below 0. Any push or pop not gated by the
//    handshake has no effect.
// TESTING
//  1 Reset with RESETBAR=0 held 3 cycles at random inputs -> OUT_VALID=0, COUNT=0,
//    RAILERR=0, IN_READY=1.
//  2 Push Y=0, COUT=1, COUTBAR=0 with OUT_READY=1 -> next cycle OUT_VALID=1,
//    RESULT=0, Z=1, N=0, C=1. Entry popped the following edge.
//  3 OUT_READY=0; push 32'h8000_0001 then 32'h0000_0005 -> COUNT=2, IN_READY=0.
//    A third push of 32'hFFFF_FFFF is ignored. The head shows N=1.
//  4 Continuing from 3: OUT_READY=1 and IN_VALID=1 with 32'h0000_0007 -> pop order
//    8000_0001, 0000_0005, 0000_0007. COUNT goes 2->1->1->0.
//  5 Push with COUT=COUTBAR=1 -> RAILERR=1, entry delivered. CLRERR pulse -> 0.
//    A set and CLRERR in the same cycle -> RAILERR stays 1.
//  6 RESETBAR pulsed low mid-cycle with COUNT=2 -> asynchronous clear. The
//    post-reset push of 32'h0000_0003 is the only entry delivered.

Source files
------------

// File: rtl/dpcomp_flag_stage.sv
// dpcomp_flag_stage: captures the comparator column result and carry rails, derives Z/N/C flags, holds them in a 2-entry skid buffer
// Ports:
//   CLK        clock, rising edge
//   RESETBAR   asynchronous active-low reset
//   IN_VALID   column result valid       IN_READY  stage can accept (COUNT != 2)
//   Y          column result word        COUT/COUTBAR  carry rail pair
//   OUT_VALID  head entry valid          OUT_READY consumer takes head entry
//   RESULT     head result word          ZFLAG/NFLAG/CFLAG  head flags
//   RAILERR    sticky carry-rail fault   CLRERR    synchronous clear of RAILERR
//   COUNT      entries held, 0..2
module dpcomp_flag_stage #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESETBAR,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] Y,
    input  logic             COUT,
    input  logic             COUTBAR,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZFLAG,
    output logic             NFLAG,
    output logic             CFLAG,
    output logic             RAILERR,
    input  logic             CLRERR,
    output logic [1:0]       COUNT
);
    localparam int EW = WIDTH + 3;
    logic [EW-1:0] ent_q [2];
    logic [EW-1:0] ent_d [2];
    logic          head_q, head_d, tail_q, tail_d;
    logic [1:0]    count_q, count_d;
    logic          railerr_q, railerr_d;
    logic          push, pop, rail_bad;
    logic [EW-1:0] head_ent;
    always_comb begin
        push      = IN_VALID && (count_q != 2'd2);
        pop       = (count_q != 2'd0) && OUT_READY;
        // Case inequality so an X/Z rail also counts as a fault.
        rail_bad  = (COUT ^ COUTBAR) !== 1'b1;
        ent_d     = ent_q;
        if (push) ent_d[tail_q] = {COUT, Y[WIDTH-1], Y == '0, Y};
        head_d    = head_q ^ pop;
        tail_d    = tail_q ^ push;
        count_d   = count_q + {1'b0, push} - {1'b0, pop};
        railerr_d = (push && rail_bad) ? 1'b1 : CLRERR ? 1'b0 : railerr_q;
        // When empty the head has already moved past the last popped entry.
        head_ent  = (count_q == 2'd0) ? ent_q[~head_q] : ent_q[head_q];
    end
    always_ff @(posedge CLK or negedge RESETBAR) begin
        if (!RESETBAR) begin
            ent_q     <= '{default: '0};
            head_q    <= 1'b0;
            tail_q    <= 1'b0;
            count_q   <= 2'd0;
            railerr_q <= 1'b0;
        end else begin
            ent_q     <= ent_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            railerr_q <= railerr_d;
        end
    end
    assign IN_READY = count_q != 2'd2;
    assign OUT_VALID = count_q != 2'd0;
    assign {CFLAG, NFLAG, ZFLAG, RESULT} = head_ent;
    assign RAILERR = railerr_q;
    assign COUNT = count_q;
endmodule

// File: tb/tb_dpcomp_flag_stage.sv
// tb_dpcomp_flag_stage: directed-vector scoreboard bench for dpcomp_flag_stage
module tb_dpcomp_flag_stage;
    logic        CLK = 1'b0, RESETBAR = 1'b0, IN_VALID = 1'b0, IN_READY;
    logic [31:0] Y = '0, RESULT;
    logic        COUT = 1'b0, COUTBAR = 1'b1, OUT_VALID, OUT_READY = 1'b0;
    logic        ZFLAG, NFLAG, CFLAG, RAILERR, CLRERR = 1'b0;
    logic [1:0]  COUNT;
    int          vectors = 0, miscompares = 0, delivered = 0;
    logic [34:0] exp_q [$];

    dpcomp_flag_stage #(.WIDTH(32)) dut (
        .CLK(CLK), .RESETBAR(RESETBAR), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .Y(Y), .COUT(COUT), .COUTBAR(COUTBAR), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .RESULT(RESULT), .ZFLAG(ZFLAG), .NFLAG(NFLAG),
        .CFLAG(CFLAG), .RAILERR(RAILERR), .CLRERR(CLRERR), .COUNT(COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a handshake seen at the negedge completes at the next rising edge.
    always @(negedge CLK) begin
        if (RESETBAR && OUT_VALID && OUT_READY) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_output: got %h expected none", RESULT);
            end else begin
                chk("pop_entry", {CFLAG, NFLAG, ZFLAG, RESULT}, exp_q.pop_front());
            end
            delivered++;
        end
    end

    // One attempted push; the expected entry is queued only if the stage accepts it.
    task automatic send(input logic [31:0] y, input logic co, input logic cb,
                        input logic ez, input logic en, input logic ec, output bit acc);
        IN_VALID = 1'b1;
        Y = y;
        COUT = co;
        COUTBAR = cb;
        @(negedge CLK);
        acc = IN_READY;
        if (acc) exp_q.push_back({ec, en, ez, y});
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        IN_VALID = 1'b0;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int base;
        // 1: reset held 3 cycles with random inputs
        repeat (3) begin
            IN_VALID = 1'($urandom);
            Y = $urandom;
            COUT = 1'($urandom);
            COUTBAR = 1'($urandom);
            OUT_READY = 1'($urandom);
            CLRERR = 1'($urandom);
            @(posedge CLK);
            #1;
        end
        chk("reset_out_valid", 35'(OUT_VALID), 35'd0);
        chk("reset_count", 35'(COUNT), 35'd0);
        chk("reset_railerr", 35'(RAILERR), 35'd0);
        chk("reset_in_ready", 35'(IN_READY), 35'd1);
        chk("reset_result_flags", {CFLAG, NFLAG, ZFLAG, RESULT}, 35'd0);
        IN_VALID = 0; Y = 0; COUT = 0; COUTBAR = 1; OUT_READY = 0; CLRERR = 0;
        RESETBAR = 1'b1;
        idle(1);
        // 2: zero result with carry, popped on the following edge
        OUT_READY = 1'b1;
        send(32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, acc);
        IN_VALID = 1'b0;
        chk("t2_out_valid", 35'(OUT_VALID), 35'd1);
        chk("t2_head", {CFLAG, NFLAG, ZFLAG, RESULT}, {1'b1, 1'b0, 1'b1, 32'h0});
        idle(1);
        chk("t2_count_after_pop", 35'(COUNT), 35'd0);
        chk("t2_hold_last_popped", {CFLAG, NFLAG, ZFLAG, RESULT}, {1'b1, 1'b0, 1'b1, 32'h0});
        // 3: fill with OUT_READY low, third push refused
        OUT_READY = 1'b0;
        send(32'h8000_0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, acc);
        send(32'h0000_0005, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, acc);
        chk("t3_count_full", 35'(COUNT), 35'd2);
        chk("t3_in_ready_full", 35'(IN_READY), 35'd0);
        send(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, acc);
        chk("t3_third_refused", 35'(acc), 35'd0);
        chk("t3_count_still_full", 35'(COUNT), 35'd2);
        chk("t3_head_n", {NFLAG, 2'b00, RESULT}, {1'b1, 2'b00, 32'h8000_0001});
        // 4: drain while offering a new entry
        OUT_READY = 1'b1;
        send(32'h0000_0007, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, acc);
        chk("t4_first_refused", 35'(acc), 35'd0);
        chk("t4_count_a", 35'(COUNT), 35'd1);
        send(32'h0000_0007, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, acc);
        IN_VALID = 1'b0;
        chk("t4_second_accepted", 35'(acc), 35'd1);
        chk("t4_count_b", 35'(COUNT), 35'd1);
        idle(1);
        chk("t4_count_c", 35'(COUNT), 35'd0);
        chk("t4_hold_last", 35'(RESULT), 35'h7);
        // 5: rail fault, clear, and set-beats-clear
        send(32'h0000_1234, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, acc);
        IN_VALID = 1'b0;
        chk("t5_railerr_set", 35'(RAILERR), 35'd1);
        idle(1);
        chk("t5_railerr_sticky", 35'(RAILERR), 35'd1);
        CLRERR = 1'b1;
        idle(1);
        CLRERR = 1'b0;
        chk("t5_railerr_cleared", 35'(RAILERR), 35'd0);
        CLRERR = 1'b1;
        send(32'h0000_0055, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        IN_VALID = 1'b0;
        CLRERR = 1'b0;
        chk("t5_set_wins", 35'(RAILERR), 35'd1);
        CLRERR = 1'b1;
        idle(1);
        CLRERR = 1'b0;
        chk("t5_railerr_final_clear", 35'(RAILERR), 35'd0);
        idle(2);
        chk("t5_drained", 35'(COUNT), 35'd0);
        // 6: asynchronous reset mid-cycle with the stage full
        OUT_READY = 1'b0;
        send(32'h0000_000A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, acc);
        send(32'h0000_000B, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, acc);
        IN_VALID = 1'b0;
        chk("t6_full_before_reset", 35'(COUNT), 35'd2);
        #2;
        RESETBAR = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_async_count", 35'(COUNT), 35'd0);
        chk("t6_async_out_valid", 35'(OUT_VALID), 35'd0);
        chk("t6_async_in_ready", 35'(IN_READY), 35'd1);
        @(posedge CLK);
        #1;
        RESETBAR = 1'b1;
        base = delivered;
        OUT_READY = 1'b1;
        send(32'h0000_0003, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        idle(4);
        chk("t6_only_one_delivered", 35'(delivered - base), 35'd1);
        chk("scoreboard_empty", 35'(exp_q.size()), 35'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
